// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Entry layout is {pc, inst}; INST_NOP is the bubble decode inserts.
package if_id_pkg;

    localparam int ADDR_W = 6;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for if_id_queue: one write port, one async read port.
// Contents are not reset; validity is tracked by the queue pointers.
module if_id_queue_mem
    import if_id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  ifq_entry_t       wdata,
    input  logic [AW-1:0]    raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t mem [DEPTH];

    // write the pushed entry at the tail slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with valid/ready on both sides and flush.
// Define IF_ID_QUEUE_BYPASS_EN for a combinational empty-queue bypass.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = if_id_pkg::ADDR_W,
    parameter int INST_W = if_id_pkg::INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] head;
    logic [AW:0] tail;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    ifq_entry_t  wr_entry;
    ifq_entry_t  rd_entry;

    assign empty = (head == tail);
    assign full  = (head[AW-1:0] == tail[AW-1:0]) &&
                   (head[AW] != tail[AW]);
    assign count = tail - head;

    // held low through reset so fetch never pushes into a resetting queue
    assign in_ready = rst && !full;
    assign pop      = !empty && out_ready && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic byp;

    assign byp       = empty && in_valid && !flush;
    assign push      = in_valid && in_ready && !flush &&
                       !(byp && out_ready);
    assign out_valid = !empty || byp;
`else
    assign push      = in_valid && in_ready && !flush;
    assign out_valid = !empty;
`endif

    assign wr_entry.pc   = in_pc;
    assign wr_entry.inst = in_inst;

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail[AW-1:0]),
        .wdata (wr_entry),
        .raddr (head[AW-1:0]),
        .rdata (rd_entry)
    );

    // pointer update; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
        end
    end

    // head entry to decode, zero when nothing is presented
    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (!empty) begin
            out_pc   = rd_entry.pc;
            out_inst = rd_entry.inst;
        end
`ifdef IF_ID_QUEUE_BYPASS_EN
        else if (byp) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
`endif
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    if_id_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input int pc);
        return 32'h1000_0000 | pc;
    endfunction

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;

        // reset state
        #30;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_out_pc", {26'd0, out_pc}, 0);
        chk("rst_out_inst", out_inst, 0);
        #40;
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // single push
        in_valid = 1'b1;
        in_pc    = 6'd0;
        in_inst  = 32'h0000_0093;
        step();
        chk("push1_valid", {31'd0, out_valid}, 1);
        chk("push1_pc", {26'd0, out_pc}, 0);
        chk("push1_inst", out_inst, 32'h0000_0093);
        chk("push1_count", {29'd0, count}, 1);

        // fill to full, pc 4 must be refused
        for (int p = 1; p <= 3; p++) begin
            in_pc   = 6'(p);
            in_inst = ins(p);
            step();
            chk("fill_count", {29'd0, count}, 32'(p + 1));
        end
        chk("full_in_ready", {31'd0, in_ready}, 0);
        chk("full_head_pc", {26'd0, out_pc}, 0);
        in_pc   = 6'd4;
        in_inst = ins(4);
        step();
        chk("full_no_push", {29'd0, count}, 4);

        // pop while full with in_valid high: no push that cycle
        out_ready = 1'b1;
        step();
        chk("fullpop_count", {29'd0, count}, 3);
        chk("fullpop_pc", {26'd0, out_pc}, 1);
        chk("fullpop_in_ready", {31'd0, in_ready}, 1);
        in_valid = 1'b0;
        for (int p = 2; p <= 3; p++) begin
            step();
            chk("drain_pc", {26'd0, out_pc}, 32'(p));
            chk("drain_inst", out_inst, ins(p));
        end
        step();
        chk("drained_count", {29'd0, count}, 0);
        chk("drained_valid", {31'd0, out_valid}, 0);
        chk("drained_pc", {26'd0, out_pc}, 0);
        chk("drained_inst", out_inst, 0);
        step();
        chk("empty_pop_ignored", {29'd0, count}, 0);

        // simultaneous push/pop at count 2, pointers wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int p = 0; p <= 1; p++) begin
            in_pc   = 6'(p);
            in_inst = ins(p);
            step();
        end
        chk("pp_start_count", {29'd0, count}, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_pc   = 6'(i + 2);
            in_inst = ins(i + 2);
            #1;
            chk("pp_pc", {26'd0, out_pc}, 32'(i));
            chk("pp_inst", out_inst, ins(i));
            chk("pp_count", {29'd0, count}, 2);
            step();
        end
        chk("pp_end_pc", {26'd0, out_pc}, 10);
        chk("pp_end_count", {29'd0, count}, 2);

        // flush at count 3 with a concurrent push of pc 7
        out_ready = 1'b0;
        in_pc     = 6'd12;
        in_inst   = ins(12);
        step();
        chk("preflush_count", {29'd0, count}, 3);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_pc     = 6'd7;
        in_inst   = ins(7);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_count", {29'd0, count}, 0);
        chk("flush_valid", {31'd0, out_valid}, 0);
        chk("flush_pc", {26'd0, out_pc}, 0);
        step();
        chk("flush_no_pc7", {31'd0, out_valid}, 0);

        // asynchronous reset mid-operation at count 2
        in_valid = 1'b1;
        for (int p = 20; p <= 21; p++) begin
            in_pc   = 6'(p);
            in_inst = ins(p);
            step();
        end
        in_valid = 1'b0;
        chk("prerst_count", {29'd0, count}, 2);
        chk("prerst_pc", {26'd0, out_pc}, 20);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_count", {29'd0, count}, 0);
        chk("arst_pc", {26'd0, out_pc}, 0);
        chk("arst_in_ready", {31'd0, in_ready}, 0);
        #2;
        rst = 1'b1;
        step();

        // empty-queue presentation of pc 9
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pc     = 6'd9;
        in_inst   = ins(9);
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        chk("byp_valid", {31'd0, out_valid}, 1);
        chk("byp_pc", {26'd0, out_pc}, 9);
        chk("byp_inst", out_inst, ins(9));
        chk("byp_count", {29'd0, count}, 0);
        step();
        in_valid = 1'b0;
        #1;
        chk("byp_after_count", {29'd0, count}, 0);
        chk("byp_after_valid", {31'd0, out_valid}, 0);
`else
        chk("nobyp_valid", {31'd0, out_valid}, 0);
        chk("nobyp_pc", {26'd0, out_pc}, 0);
        step();
        in_valid = 1'b0;
        #1;
        chk("nobyp_late_valid", {31'd0, out_valid}, 1);
        chk("nobyp_late_pc", {26'd0, out_pc}, 9);
        chk("nobyp_late_count", {29'd0, count}, 1);
        step();
        chk("nobyp_pop_count", {29'd0, count}, 0);
        chk("nobyp_pop_valid", {31'd0, out_valid}, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
